// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port among NREQ requesters.
// One-cycle arbitration; winc/req_ready gated combinationally by wfull. Define FIFOARB_LOCK_EN for whole-packet grants.
module fifo_wr_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int DSIZE    = 8,
  parameter  int MAXBURST = 16,
  localparam int IDW      = $clog2(NREQ),
  localparam int CW       = $clog2(MAXBURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] gnt, gnt_nxt;
  logic [IDW-1:0] rr_last, rr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic [IDW-1:0] pick_hi, pick_lo;
  logic           hi_vld, lo_vld;
  logic           sel_vld, sel_last, beat, rel_grant;

  // Two-pass rotate: first requester above rr_last, else the lowest one (wrap-around).
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_vld && req_valid[i] && (IDW'(i) > rr_last)) begin
        pick_hi = IDW'(i);
        hi_vld  = 1'b1;
      end
      if (!lo_vld && req_valid[i]) begin
        pick_lo = IDW'(i);
        lo_vld  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    wdata   = req_data[DSIZE-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_vld = req_valid[i];
        wdata   = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

`ifdef FIFOARB_LOCK_EN
  always_comb begin
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) sel_last = req_last[i];
    end
  end
`else
  logic unused_last;
  assign sel_last    = 1'b0;
  assign unused_last = ^{req_last, sel_last};
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_last;
    cnt_nxt   = cnt;
    req_ready = '0;
    beat      = 1'b0;
    rel_grant = 1'b0;
    case (state)
      IDLE: begin
        if (lo_vld) begin
          gnt_nxt   = hi_vld ? pick_hi : pick_lo;
          rr_nxt    = hi_vld ? pick_hi : pick_lo;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = (gnt == IDW'(i)) & ~wfull;
        end
        beat = sel_vld & ~wfull;
`ifdef FIFOARB_LOCK_EN
        if (beat && cnt != CW'(MAXBURST)) cnt_nxt = cnt + CW'(1);
        rel_grant = beat & sel_last;
`else
        if (beat) cnt_nxt = cnt + CW'(1);
        rel_grant = ~sel_vld | (beat & (cnt == CW'(MAXBURST - 1)));
`endif
        if (rel_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      rr_last <= IDW'(NREQ - 1);
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      rr_last <= rr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign winc     = beat;
  assign grant_id = gnt;
  assign busy     = (state == XFER);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a grant-level reference model. Build with FIFOARB_LOCK_EN to exercise packet lock.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DSIZE = 8, MAXBURST = 16, IDW = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid, req_last, req_ready;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull, winc, busy;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        grant_id;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: who owns the port, who owned it last, beats granted so far.
  bit m_busy;
  int m_owner, m_prev, m_beats;
  logic [DSIZE-1:0] fifo_q[$];
  logic o_winc, o_busy;
  logic [IDW-1:0] o_gid;
  logic [NREQ-1:0] o_rdy;

  function automatic logic [DSIZE-1:0] data_of(input int i);
    return req_data[i*DSIZE +: DSIZE];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_prev = NREQ - 1; m_beats = 0;
  endtask

  task automatic cycle();
    bit beat, rel;
    int pick;
    @(negedge wclk);
    if (!wrst_n) model_reset();
    o_winc = winc; o_busy = busy; o_gid = grant_id; o_rdy = req_ready;
    beat = m_busy && req_valid[m_owner] && !wfull;
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_owner);
    chk("wdata", wdata, data_of(m_owner));
    chk("req_ready", req_ready, (m_busy && !wfull) ? (1 << m_owner) : 0);
    chk("winc", winc, beat);
    if (winc) fifo_q.push_back(wdata);
    if (wrst_n) begin
      if (!m_busy) begin
        pick = -1;
        for (int k = 1; k <= NREQ; k++)
          if (pick < 0 && req_valid[(m_prev + k) % NREQ]) pick = (m_prev + k) % NREQ;
        if (pick >= 0) begin
          m_owner = pick; m_prev = pick; m_beats = 0; m_busy = 1;
        end
      end else begin
        if (beat) m_beats++;
`ifdef FIFOARB_LOCK_EN
        if (m_beats > MAXBURST) m_beats = MAXBURST;
        rel = beat && req_last[m_owner];
`else
        rel = !req_valid[m_owner] || m_beats == MAXBURST;
`endif
        if (rel) m_busy = 0;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic drive_bp(input int nb);
    req_data = $urandom;
    req_data[2*DSIZE +: DSIZE] = 8'hA0 + 8'(nb);
    req_last = (nb == MAXBURST - 1) ? 4'b0100 : 4'b0000;
  endtask

  initial begin
    int nb, gapc;
    bit done;
    wrst_n = 0; req_valid = '0; req_last = '0; req_data = '0; wfull = 0;
    model_reset();

    // Reset with everybody requesting: nothing moves.
    req_valid = 4'hF;
    repeat (3) begin
      req_data = $urandom;
      cycle();
      chk("rst_winc", o_winc, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_gid", o_gid, 0);
    end
    wrst_n = 1;

    // Priority rotation 0,1,2,3,0: bubble then MAXBURST beats each.
    for (int g = 0; g < 5; g++) begin
      req_data = $urandom; req_last = '0;
      cycle();
      chk("prio_bubble", o_busy, 0);
      for (int b = 0; b < MAXBURST; b++) begin
        req_data = $urandom;
        req_last = (b == MAXBURST - 1) ? 4'hF : 4'h0;
        cycle();
        chk("prio_winc", o_winc, 1);
        chk("prio_gid", o_gid, g % NREQ);
      end
    end
    req_valid = '0; req_last = '0;
    cycle();

    // Backpressure on requester 2 after beat 3.
    req_valid = 4'b0100; nb = 0; fifo_q.delete();
    for (int t = 0; t < 20 && nb < 3; t++) begin
      drive_bp(nb); cycle();
      if (o_winc) nb++;
    end
    chk("bp_pre_beats", nb, 3);
    wfull = 1;
    repeat (5) begin
      drive_bp(nb); cycle();
      chk("bp_winc", o_winc, 0);
      chk("bp_ready2", o_rdy[2], 0);
      chk("bp_busy", o_busy, 1);
    end
    wfull = 0; done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      drive_bp(nb); cycle();
      if (o_winc) nb++;
      else if (!o_busy) done = 1;
    end
    chk("bp_done", done, 1);
    chk("bp_beats", nb, MAXBURST);
    chk("bp_count", fifo_q.size(), MAXBURST);
    for (int k = 0; k < MAXBURST; k++)
      if (k < fifo_q.size()) chk("bp_word", fifo_q[k], 8'hA0 + k);
    req_valid = '0; req_last = '0;
    cycle(); cycle();

    wrst_n = 0; cycle(); wrst_n = 1;
`ifndef FIFOARB_LOCK_EN
    // Valid gap releases requester 1 in favour of waiting requester 3.
    req_valid = 4'b1010;
    cycle();
    chk("gap_idle", o_busy, 0);
    repeat (5) begin
      req_data = $urandom; cycle();
      chk("gap_gid", o_gid, 1);
      chk("gap_winc", o_winc, 1);
    end
    req_valid = 4'b1000;
    cycle();
    chk("gap_cycle_busy", o_busy, 1);
    chk("gap_cycle_winc", o_winc, 0);
    cycle();
    chk("gap_bubble", o_busy, 0);
    cycle();
    chk("gap_next_gid", o_gid, 3);
    chk("gap_next_busy", o_busy, 1);
`else
    // 20-beat packet with a 2-cycle gap stays contiguous under grant 0.
    req_valid = 4'b0011; nb = 0; gapc = 0;
    cycle();
    chk("lock_idle", o_busy, 0);
    for (int t = 0; t < 40 && nb < 20; t++) begin
      req_data = $urandom;
      req_valid[0] = 1'b1;
      if (nb == 10 && gapc < 2) begin req_valid[0] = 1'b0; gapc++; end
      req_last = (nb == 19) ? 4'b0011 : 4'b0000;
      cycle();
      chk("lock_gid", o_gid, 0);
      chk("lock_busy", o_busy, 1);
      if (o_winc) nb++;
    end
    chk("lock_beats", nb, 20);
    req_valid[0] = 1'b0; req_last = '0;
    cycle();
    chk("lock_bubble", o_busy, 0);
    cycle();
    chk("lock_next_gid", o_gid, 1);
`endif
    req_valid = '0; req_last = '0;
    cycle();

    // Reset during beat 7 of requester 2.
    wrst_n = 0; cycle(); wrst_n = 1;
    req_valid = 4'b0100; nb = 0;
    cycle();
    for (int t = 0; t < 20 && nb < 6; t++) begin
      req_data = $urandom; cycle();
      if (o_winc) nb++;
    end
    chk("mid_pre_beats", nb, 6);
    wrst_n = 0;
    cycle();
    chk("mid_winc", o_winc, 0);
    chk("mid_gid", o_gid, 0);
    chk("mid_busy", o_busy, 0);
    wrst_n = 1; req_valid = 4'hF;
    cycle();
    chk("mid_idle", o_busy, 0);
    cycle();
    chk("mid_first_gid", o_gid, 0);
    chk("mid_first_busy", o_busy, 1);

    // Random traffic with sticky valids, sporadic full and rare reset.
    req_valid = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 5) == 0) req_valid[i] = ~req_valid[i];
      req_data = $urandom;
      req_last = 4'($urandom);
      wfull    = ($urandom_range(0, 4) == 0);
      wrst_n   = ($urandom_range(0, 499) != 0);
      cycle();
    end
    wrst_n = 1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
